data_mem_ctrl: RTL

//  Parametrised data-memory controller for the MEM stage; successor to the combinational DPI data SRAM.

---
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-outstanding data-memory controller with programmable response latency
// Byte-lane aligned loads/stores, sign/zero extension, misaligned and out-of-range fault reporting.
module data_mem_ctrl #(
   parameter int unsigned     XLEN    = 32,
   parameter int unsigned     DEPTH   = 4096,
   parameter logic [XLEN-1:0] BASE    = 32'h8000_0000,
   parameter int unsigned     LATENCY = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned     IDX_W    = $clog2(DEPTH);
   localparam logic [XLEN-1:0] LAST     = BASE + XLEN'(DEPTH * 4) - XLEN'(1);
   localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [XLEN-1:0] mem_q [DEPTH];

   logic             accept, misaligned, in_range, fault, wr_en, sx;
   logic [IDX_W-1:0] idx;
   logic [XLEN-1:0]  rd_word, ld_data, wr_data;
   logic [3:0]       wr_mask;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign accept    = req_valid && req_ready;

   // BASE is aligned to the array size, so its low index bits are zero and this subtraction is exact.
   assign idx      = req_addr[IDX_W+1:2] - BASE[IDX_W+1:2];
   assign in_range = (req_addr >= BASE) && (req_addr <= LAST);
   assign fault    = misaligned || !in_range;
   assign wr_en    = accept && req_we && !fault;
   assign rd_word  = mem_q[idx];
   assign ld_byte  = 8'(rd_word >> {req_addr[1:0], 3'b000});
   assign ld_half  = 16'(rd_word >> {req_addr[1], 4'b0000});
   assign sx       = !req_unsigned;

   always_comb begin
      misaligned = 1'b0;
      ld_data    = rd_word;
      wr_data    = req_wdata;
      wr_mask    = 4'b1111;
      case (req_size)
         2'b00: begin
            ld_data = {{24{sx & ld_byte[7]}}, ld_byte};
            wr_data = {4{req_wdata[7:0]}};
            wr_mask = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            misaligned = req_addr[0];
            ld_data    = {{16{sx & ld_half[15]}}, ld_half};
            wr_data    = {2{req_wdata[15:0]}};
            wr_mask    = 4'b0011 << {req_addr[1], 1'b0};
         end
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               err_d   = fault;
               rdata_d = (fault || req_we) ? '0 : ld_data;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately outside the reset domain: contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule
